// File: rtl/thermo_pkg.sv
// Shared definitions for the thermometer-frame path: defaults, state encoding and
// the legality/popcount helpers also reused by the upstream pattern-memory checker.
package thermo_pkg;

    localparam int WIDTH_DEF    = 8;
    localparam int CODE_W_DEF   = 3;
    localparam int THERMO_MAX_W = 64;
    localparam int THERMO_POP_W = 7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } thermo_state_e;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    // Callers zero-extend narrower words; the extra carry bit keeps all-ones legal.
    function automatic logic thermo_is_legal(input logic [THERMO_MAX_W-1:0] w);
        logic [THERMO_MAX_W:0] inc;
        inc = {1'b0, w} + {{THERMO_MAX_W{1'b0}}, 1'b1};
        return (w != {THERMO_MAX_W{1'b0}}) && (({1'b0, w} & inc) == {(THERMO_MAX_W+1){1'b0}});
    endfunction

    function automatic logic [THERMO_POP_W-1:0] thermo_popcount(input logic [THERMO_MAX_W-1:0] w);
        logic [THERMO_POP_W-1:0] cnt;
        cnt = {THERMO_POP_W{1'b0}};
        for (int i = 0; i < THERMO_MAX_W; i++) begin
            cnt = cnt + {{(THERMO_POP_W-1){1'b0}}, w[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/thermo_decode.sv
// Combinational thermometer word -> {code, err} decoder.
module thermo_decode
    import thermo_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic [WIDTH-1:0]  word,
    output logic [CODE_W-1:0] code,
    output logic              err
);

    logic [THERMO_POP_W-1:0] pop_s;
    logic                    legal_s;

    // Illegal words report code 0 so downstream never sees a stale-looking value.
    always_comb begin
        pop_s   = thermo_popcount(THERMO_MAX_W'(word));
        legal_s = thermo_is_legal(THERMO_MAX_W'(word));
        if (legal_s) begin
            code = CODE_W'(pop_s - {{(THERMO_POP_W-1){1'b0}}, 1'b1});
            err  = 1'b0;
        end else begin
            code = {CODE_W{1'b0}};
            err  = 1'b1;
        end
    end

endmodule

// File: rtl/thermo_frame_rx.sv
// Serial thermometer-frame receiver with a one-entry valid/ack output buffer.
// Optional CHG output (code-change pulse) is enabled by defining THERMO_RX_CHANGE_EN.
module thermo_frame_rx
    import thermo_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int CODE_W = CODE_W_DEF
) (
    input  logic              CLK,
    input  logic              CLEAR_N,
    input  logic              SYNC,
    input  logic              DIN,
    input  logic              ACK,
    output logic              VALID,
    output logic [WIDTH-1:0]  WORD,
    output logic [CODE_W-1:0] CODE,
    output logic              ERR,
    output logic              OVERRUN
`ifdef THERMO_RX_CHANGE_EN
    ,
    output logic              CHG
`endif
);

    logic [0:0]        state_q, state_d;
    logic [CODE_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  frame_word_s;
    logic              frame_done_s;
    logic [CODE_W-1:0] dec_code_s;
    logic              dec_err_s;

    logic              valid_q, valid_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              err_q, err_d;
    logic              overrun_q, overrun_d;
`ifdef THERMO_RX_CHANGE_EN
    logic              chg_q, chg_d;
    logic [CODE_W-1:0] last_code_q, last_code_d;
    logic              have_legal_q, have_legal_d;
`endif

    thermo_decode #(
        .WIDTH  (WIDTH),
        .CODE_W (CODE_W)
    ) u_decode (
        .word (frame_word_s),
        .code (dec_code_s),
        .err  (dec_err_s)
    );

    // Frame assembly; SYNC always restarts at bit 0 and outranks completion.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        frame_done_s  = 1'b0;
        frame_word_s  = shift_q;
        frame_word_s[cnt_q] = DIN;
        if (SYNC) begin
            state_d = ST_RECV;
            cnt_d   = {{(CODE_W-1){1'b0}}, 1'b1};
            shift_d = {{(WIDTH-1){1'b0}}, DIN};
        end else if (state_q == ST_RECV) begin
            shift_d = frame_word_s;
            if (cnt_q == CODE_W'(WIDTH-1)) begin
                frame_done_s = 1'b1;
                state_d      = ST_IDLE;
                cnt_d        = {CODE_W{1'b0}};
            end else begin
                cnt_d = cnt_q + {{(CODE_W-1){1'b0}}, 1'b1};
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Output buffer: fill on completion, drain on ACK, drop and flag when full.
    always_comb begin
        valid_d      = valid_q;
        word_d       = word_q;
        code_d       = code_q;
        err_d        = err_q;
        overrun_d    = overrun_q;
`ifdef THERMO_RX_CHANGE_EN
        chg_d        = 1'b0;
        last_code_d  = last_code_q;
        have_legal_d = have_legal_q;
`endif
        if (frame_done_s) begin
            if (!valid_q || ACK) begin
                valid_d = 1'b1;
                word_d  = frame_word_s;
                code_d  = dec_code_s;
                err_d   = dec_err_s;
`ifdef THERMO_RX_CHANGE_EN
                if (!dec_err_s) begin
                    chg_d        = !have_legal_q || (dec_code_s != last_code_q);
                    last_code_d  = dec_code_s;
                    have_legal_d = 1'b1;
                end else begin
                    chg_d = 1'b0;
                end
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ACK) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CODE_W{1'b0}};
            shift_q      <= {WIDTH{1'b0}};
            valid_q      <= 1'b0;
            word_q       <= {WIDTH{1'b0}};
            code_q       <= {CODE_W{1'b0}};
            err_q        <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef THERMO_RX_CHANGE_EN
            chg_q        <= 1'b0;
            last_code_q  <= {CODE_W{1'b0}};
            have_legal_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            valid_q      <= valid_d;
            word_q       <= word_d;
            code_q       <= code_d;
            err_q        <= err_d;
            overrun_q    <= overrun_d;
`ifdef THERMO_RX_CHANGE_EN
            chg_q        <= chg_d;
            last_code_q  <= last_code_d;
            have_legal_q <= have_legal_d;
`endif
        end
    end

    assign VALID   = valid_q;
    assign WORD    = word_q;
    assign CODE    = code_q;
    assign ERR     = err_q;
    assign OVERRUN = overrun_q;
`ifdef THERMO_RX_CHANGE_EN
    assign CHG     = chg_q;
`endif

endmodule

// File: tb/tb_thermo_frame_rx.sv
// Scoreboard bench for thermo_frame_rx; covers CHG when THERMO_RX_CHANGE_EN is defined.
module tb_thermo_frame_rx;

    localparam int WIDTH  = 8;
    localparam int CODE_W = 3;

    logic              CLK;
    logic              CLEAR_N;
    logic              SYNC;
    logic              DIN;
    logic              ACK;
    logic              VALID;
    logic [WIDTH-1:0]  WORD;
    logic [CODE_W-1:0] CODE;
    logic              ERR;
    logic              OVERRUN;
`ifdef THERMO_RX_CHANGE_EN
    logic              CHG;
`endif

    typedef struct {
        logic [WIDTH-1:0]  word;
        logic [CODE_W-1:0] code;
        logic              err;
        logic              chg;
    } exp_t;

    exp_t              sb[$];
    exp_t              e_r;
    int                n_chk;
    int                n_pass;
    logic              m_have;
    logic [CODE_W-1:0] m_last;

    thermo_frame_rx #(.WIDTH(WIDTH), .CODE_W(CODE_W)) dut (
        .CLK     (CLK),
        .CLEAR_N (CLEAR_N),
        .SYNC    (SYNC),
        .DIN     (DIN),
        .ACK     (ACK),
        .VALID   (VALID),
        .WORD    (WORD),
        .CODE    (CODE),
        .ERR     (ERR),
        .OVERRUN (OVERRUN)
`ifdef THERMO_RX_CHANGE_EN
        ,
        .CHG     (CHG)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: legal words are exactly 2^k-1 for k=1..WIDTH.
    function automatic void push_exp(input logic [WIDTH-1:0] w);
        exp_t e;
        logic [WIDTH:0] pat;
        e.word = w;
        e.code = '0;
        e.err  = 1'b1;
        e.chg  = 1'b0;
        for (int k = 1; k <= WIDTH; k++) begin
            pat = (9'd1 << k) - 9'd1;
            if ({1'b0, w} == pat) begin
                e.err  = 1'b0;
                e.code = CODE_W'(k - 1);
            end
        end
        if (!e.err) begin
            e.chg  = !m_have || (e.code != m_last);
            m_have = 1'b1;
            m_last = e.code;
        end
        sb.push_back(e);
    endfunction

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input logic ack_first, input logic ack_last);
        for (int i = 0; i < WIDTH; i++) begin
            SYNC = (i == 0);
            DIN  = w[i];
            ACK  = ((i == 0) && ack_first) || ((i == WIDTH-1) && ack_last);
            tick();
        end
        SYNC = 1'b0;
        DIN  = 1'b0;
        ACK  = 1'b0;
    endtask

    task automatic send_partial(input logic [WIDTH-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            SYNC = (i == 0);
            DIN  = w[i];
            ACK  = 1'b0;
            tick();
        end
        SYNC = 1'b0;
        DIN  = 1'b0;
    endtask

    task automatic drain();
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
    endtask

    task automatic pulse_reset();
        CLEAR_N = 1'b0;
        #1;
        m_have  = 1'b0;
        m_last  = '0;
    endtask

    task automatic test_reset();
        CLEAR_N = 1'b0;
        SYNC = 1'b0; DIN = 1'b0; ACK = 1'b0;
        m_have = 1'b0; m_last = '0;
        #2;
        n_chk++;
        if ({VALID, WORD, CODE, ERR, OVERRUN} !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b0})
            $display("FAIL reset_outputs got %b%h%0d%b%b want 0/00/0/0/0", VALID, WORD, CODE, ERR, OVERRUN);
        else n_pass++;
`ifdef THERMO_RX_CHANGE_EN
        n_chk++;
        if (CHG !== 1'b0) $display("FAIL reset_chg got %b want 0", CHG); else n_pass++;
`endif
        @(negedge CLK);
        CLEAR_N = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        push_exp(8'h07);
        send_partial(8'h07, WIDTH-1);
        n_chk++;
        if (VALID !== 1'b0) $display("FAIL basic_latency got VALID=%b want 0", VALID); else n_pass++;
        SYNC = 1'b0; DIN = 1'b0;
        tick();
        e_r = sb.pop_front();
        n_chk++;
        if ({VALID, WORD, CODE, ERR} !== {1'b1, e_r.word, e_r.code, e_r.err})
            $display("FAIL basic_frame got %b/%h/%0d/%b want 1/%h/%0d/%b", VALID, WORD, CODE, ERR, e_r.word, e_r.code, e_r.err);
        else n_pass++;
`ifdef THERMO_RX_CHANGE_EN
        n_chk++;
        if (CHG !== e_r.chg) $display("FAIL basic_chg got %b want %b", CHG, e_r.chg); else n_pass++;
`endif
        drain();
        n_chk++;
        if ({VALID, WORD} !== {1'b0, 8'h07}) $display("FAIL basic_ack got %b/%h want 0/07", VALID, WORD); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] frames [2];
        frames[0] = 8'h01;
        frames[1] = 8'hFF;
        for (int f = 0; f < 2; f++) begin
            push_exp(frames[f]);
            send_frame(frames[f], (f == 1), 1'b0);
            e_r = sb.pop_front();
            n_chk++;
            if ({VALID, WORD, CODE, ERR, OVERRUN} !== {1'b1, e_r.word, e_r.code, e_r.err, 1'b0})
                $display("FAIL b2b_frame%0d got %b/%h/%0d/%b/%b want 1/%h/%0d/%b/0", f, VALID, WORD, CODE, ERR, OVERRUN, e_r.word, e_r.code, e_r.err);
            else n_pass++;
`ifdef THERMO_RX_CHANGE_EN
            n_chk++;
            if (CHG !== e_r.chg) $display("FAIL b2b_chg%0d got %b want %b", f, CHG, e_r.chg); else n_pass++;
`endif
        end
        drain();
    endtask

    task automatic test_illegal();
        logic [WIDTH-1:0] frames [2];
        frames[0] = 8'h05;
        frames[1] = 8'h00;
        for (int f = 0; f < 2; f++) begin
            push_exp(frames[f]);
            send_frame(frames[f], 1'b0, 1'b0);
            e_r = sb.pop_front();
            n_chk++;
            if ({VALID, WORD, CODE, ERR} !== {1'b1, e_r.word, e_r.code, e_r.err})
                $display("FAIL illegal%0d got %b/%h/%0d/%b want 1/%h/%0d/%b", f, VALID, WORD, CODE, ERR, e_r.word, e_r.code, e_r.err);
            else n_pass++;
`ifdef THERMO_RX_CHANGE_EN
            n_chk++;
            if (CHG !== e_r.chg) $display("FAIL illegal_chg%0d got %b want %b", f, CHG, e_r.chg); else n_pass++;
`endif
            drain();
        end
    endtask

    task automatic test_overrun();
        push_exp(8'h03);
        send_frame(8'h03, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b0, 1'b0);
        e_r = sb.pop_front();
        n_chk++;
        if ({VALID, WORD, CODE, ERR, OVERRUN} !== {1'b1, e_r.word, e_r.code, e_r.err, 1'b1})
            $display("FAIL overrun_hold got %b/%h/%0d/%b/%b want 1/%h/%0d/%b/1", VALID, WORD, CODE, ERR, OVERRUN, e_r.word, e_r.code, e_r.err);
        else n_pass++;
        drain();
        tick();
        n_chk++;
        if ({VALID, OVERRUN} !== 2'b01) $display("FAIL overrun_sticky got VALID=%b OVERRUN=%b want 0/1", VALID, OVERRUN); else n_pass++;
        pulse_reset();
        n_chk++;
        if (OVERRUN !== 1'b0) $display("FAIL overrun_reset got %b want 0", OVERRUN); else n_pass++;
        @(negedge CLK);
        CLEAR_N = 1'b1;
        tick();
    endtask

    task automatic test_simul_ack();
        push_exp(8'h01);
        send_frame(8'h01, 1'b0, 1'b0);
        e_r = sb.pop_front();
        n_chk++;
        if ({VALID, WORD, CODE} !== {1'b1, e_r.word, e_r.code})
            $display("FAIL simul_first got %b/%h/%0d want 1/%h/%0d", VALID, WORD, CODE, e_r.word, e_r.code);
        else n_pass++;
        push_exp(8'h1F);
        send_frame(8'h1F, 1'b0, 1'b1);
        e_r = sb.pop_front();
        n_chk++;
        if ({VALID, WORD, CODE, ERR, OVERRUN} !== {1'b1, e_r.word, e_r.code, e_r.err, 1'b0})
            $display("FAIL simul_fill got %b/%h/%0d/%b/%b want 1/%h/%0d/%b/0", VALID, WORD, CODE, ERR, OVERRUN, e_r.word, e_r.code, e_r.err);
        else n_pass++;
`ifdef THERMO_RX_CHANGE_EN
        n_chk++;
        if (CHG !== e_r.chg) $display("FAIL simul_chg got %b want %b", CHG, e_r.chg); else n_pass++;
`endif
        drain();
    endtask

    task automatic test_resync();
        send_partial(8'h05, 4);
        n_chk++;
        if (VALID !== 1'b0) $display("FAIL resync_partial got VALID=%b want 0", VALID); else n_pass++;
        push_exp(8'h3F);
        send_frame(8'h3F, 1'b0, 1'b0);
        e_r = sb.pop_front();
        n_chk++;
        if ({VALID, WORD, CODE, ERR} !== {1'b1, e_r.word, e_r.code, e_r.err})
            $display("FAIL resync_frame got %b/%h/%0d/%b want 1/%h/%0d/%b", VALID, WORD, CODE, ERR, e_r.word, e_r.code, e_r.err);
        else n_pass++;
        drain();
        send_partial(8'h1F, 5);
        pulse_reset();
        n_chk++;
        if ({VALID, WORD, CODE, ERR, OVERRUN} !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b0})
            $display("FAIL midframe_reset got %b/%h/%0d/%b/%b want 0/00/0/0/0", VALID, WORD, CODE, ERR, OVERRUN);
        else n_pass++;
        @(negedge CLK);
        CLEAR_N = 1'b1;
        tick();
        push_exp(8'h3F);
        send_frame(8'h3F, 1'b0, 1'b0);
        e_r = sb.pop_front();
        n_chk++;
        if ({VALID, WORD, CODE, ERR} !== {1'b1, e_r.word, e_r.code, e_r.err})
            $display("FAIL reset_frame got %b/%h/%0d/%b want 1/%h/%0d/%b", VALID, WORD, CODE, ERR, e_r.word, e_r.code, e_r.err);
        else n_pass++;
`ifdef THERMO_RX_CHANGE_EN
        n_chk++;
        if (CHG !== e_r.chg) $display("FAIL reset_chg_first got %b want %b", CHG, e_r.chg); else n_pass++;
`endif
        drain();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_overrun();
        test_simul_ack();
        test_resync();
        n_chk++;
        if (sb.size() !== 0) $display("FAIL scoreboard_left got %0d want 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
